vector_unit_seq: RTL and testbench
==================================

# vector_unit_seq

- Clocked, element-serial vector processor; the responder for the opcode / register-address / memory-address command interface.
- Each command is accepted with a valid/ready handshake and executed one element per cycle over a 16-element vector.
- Command kinds: load, add, multiply and store, operating between four vector registers and a 512-word data memory.
- It is the execution core that instruction-issue logic and benches drive.

## Interface

Parameters:
- VLEN, 16: elements per vector register / memory block.
- WIDTH, 32: element width in bits.
- MEM_WORDS, 512: data memory depth (= 32 blocks × VLEN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- opcode  in  2  0 = add, 1 = multiply, 2 = load, 3 = store.
- reg_addr  in  2  vector register for load/store; ignored for add/multiply.
- mem_addr  in  5  memory block; word address = mem_addr*16 + element index.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle pulse in the DONE state.

## Operation

State machine: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch opcode, reg_addr and mem_addr; set idx = 0; go to EXEC.
- EXEC: one element per edge, idx 0..15. After the edge with idx = 15, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.

Per-element operations:
- load: r[reg_addr][idx] <= mem[mem_addr*16+idx].
- store: mem[mem_addr*16+idx] <= r[reg_addr][idx].
- add: 33-bit sum s = r0[idx] + r1[idx]; r2[idx] <= s[31:0]; r3[idx] <= {31'b0, s[32]}. Operands are unsigned.
- multiply: 64-bit unsigned product p = r0[idx] * r1[idx]; r2[idx] <= p[31:0]; r3[idx] <= p[63:32].

Memory:
- Read is combinational; write is synchronous.
- Only store writes memory.
- Only load, add and multiply write registers.

Input and reset handling:
- Inputs are sampled only at the handshake edge; changes during EXEC have no effect.
- cmd_valid held high while busy is ignored. It is accepted at the first edge after returning to IDLE.
- Reset: state = IDLE, idx = 0, all register elements = 0, cmd_ready = 1, busy = 0, done = 0. Memory contents are not cleared.
- Reset during EXEC aborts the command. Elements already written stay written; remaining elements are not written.
- Reset has priority over a handshake in the same cycle.

## Timing

- Handshake at edge N.
- Element i is written at edge N+1+i.
- The last element is written at edge N+16.
- done is high in the cycle after edge N+16.
- cmd_ready returns high after edge N+17.
- Back-to-back throughput: one command per 18 cycles.
- Register results of a load are visible to an add/multiply issued at the next handshake; there are no hazards, since execution is serial.

## Structure

Shared package vector_pkg holds:
- the opcode constants OP_ADD, OP_MUL, OP_LOAD, OP_STORE;
- the state enum;
- VLEN, WIDTH, MEM_WORDS.

Sub-module vector_memory:
- Instance name memory, array name mem.
- Single write port and one combinational read port.
- Benches preload and inspect it hierarchically at memory.mem[i].

## Test plan

Preload for all scenarios: mem[i] = i for i < 32; mem[i] = 2**(i%32) for i ≥ 32.

- Sum path:
  - Stimulus: load r0 <- block 0; load r1 <- block 1; add; store r2 -> 31; store r3 -> 30.
  - Expected: mem[496+i] = 16+2i and mem[480+i] = 0.
- Multiply path:
  - Stimulus: load r0 <- block 20; load r1 <- block 21; multiply; store r2 -> 16; store r3 -> 15.
  - Expected, i < 8: mem[256+i] = 2**(16+2i) and mem[240+i] = 0.
  - Expected, i ≥ 8: mem[256+i] = 0 and mem[240+i] = 2**(2i-16).
- Carry:
  - Stimulus: preload a block with 0xFFFFFFFF and another with 1; load both; add.
  - Expected: r2 elements = 0 and r3 elements = 1.
- Handshake:
  - Stimulus: keep cmd_valid high continuously with changing fields during EXEC.
  - Expected: exactly one accept per 18 cycles; done pulses exactly 1 cycle; the fields in effect are those latched at acceptance.
- Reset mid-op:
  - Stimulus: assert rst at edge N+5 of a store.
  - Expected: mem words 0..3 of the block are updated, words 4..15 are unchanged; all registers read 0; cmd_ready = 1 the next cycle.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared constants and types for the element-serial vector unit.
// Opcode encodings, FSM state type and the vector geometry.
package vector_pkg;

    localparam int VLEN      = 16;
    localparam int WIDTH     = 32;
    localparam int MEM_WORDS = 512;
    localparam int NUM_REGS  = 4;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vector_memory.sv
// Data memory for the vector unit: one synchronous write port and one
// combinational read port sharing a single address. Contents survive reset.
module vector_memory
    import vector_pkg::*;
#(
    parameter int WIDTH     = vector_pkg::WIDTH,
    parameter int MEM_WORDS = vector_pkg::MEM_WORDS,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/vector_unit_seq.sv
// Element-serial vector core: accepts one command per handshake and walks
// the 16 elements of a vector one per clock, then pulses done.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for cmd_valid
// EXEC    | processing element idx (0..VLEN-1), one per edge
// DONE    | one-cycle done pulse, then back to IDLE
module vector_unit_seq
    import vector_pkg::*;
#(
    parameter int VLEN      = vector_pkg::VLEN,
    parameter int WIDTH     = vector_pkg::WIDTH,
    parameter int MEM_WORDS = vector_pkg::MEM_WORDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] opcode,
    input  logic [1:0] reg_addr,
    input  logic [4:0] mem_addr,
    output logic       busy,
    output logic       done
);

    localparam int IDX_W  = $clog2(VLEN);
    localparam int ADDR_W = $clog2(MEM_WORDS);

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        op_q;
    logic [1:0]        reg_q;
    logic [4:0]        blk_q;

    logic [WIDTH-1:0]  vreg [NUM_REGS][VLEN];

    logic              accept;
    logic              last_elem;
    logic [ADDR_W-1:0] word_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_we;
    logic [WIDTH-1:0]  opa, opb;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH-1:0] prod;

    assign accept    = (state_q == ST_IDLE) && cmd_valid;
    assign last_elem = (idx_q == IDX_W'(VLEN - 1));
    assign word_addr = ADDR_W'(blk_q) * ADDR_W'(VLEN) + ADDR_W'(idx_q);

    assign opa  = vreg[0][idx_q];
    assign opb  = vreg[1][idx_q];
    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};

    // Gate the write with rst so an abort edge never lands a store element.
    assign mem_wdata = vreg[reg_q][idx_q];
    assign mem_we    = (state_q == ST_EXEC) && (op_q == OP_STORE) && !rst;

    vector_memory #(
        .WIDTH     (WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (last_elem) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_ADD;
            reg_q   <= '0;
            blk_q   <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int e = 0; e < VLEN; e++) begin
                    vreg[r][e] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= opcode;
                reg_q <= reg_addr;
                blk_q <= mem_addr;
                idx_q <= '0;
            end else if (state_q == ST_EXEC) begin
                idx_q <= idx_q + IDX_W'(1);
                case (op_q)
                    OP_LOAD: vreg[reg_q][idx_q] <= mem_rdata;
                    OP_ADD: begin
                        vreg[2][idx_q] <= sum[WIDTH-1:0];
                        vreg[3][idx_q] <= {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                    end
                    OP_MUL: begin
                        vreg[2][idx_q] <= prod[WIDTH-1:0];
                        vreg[3][idx_q] <= prod[2*WIDTH-1:WIDTH];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_unit_seq.sv
// Directed bench for vector_unit_seq: load/add/mul/store paths, carry,
// continuous-valid handshake and reset abort in the middle of a store.
module tb_vector_unit_seq;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] opcode;
    logic [1:0] reg_addr;
    logic [4:0] mem_addr;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    vector_unit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .opcode    (opcode),
        .reg_addr  (reg_addr),
        .mem_addr  (mem_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pow2(input int k);
        logic [31:0] one;
        one = 32'd1;
        return one << k;
    endfunction

    task automatic preload;
        for (int i = 0; i < 512; i++) begin
            dut.memory.mem[i] = (i < 32) ? 32'(i) : pow2(i % 32);
        end
    endtask

    // Issues one command and returns the number of cycles from the accepting
    // edge to the cycle in which done is seen (-1 on timeout).
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] r,
                          input logic [4:0] b, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        opcode    = op;
        reg_addr  = r;
        mem_addr  = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        opcode    = ~op;
        reg_addr  = ~r;
        mem_addr  = ~b;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        if (lat >= 40 || w >= 40) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready/busy/done got %b expected 100",
                     {cmd_ready, busy, done});
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                tests_run++;
                if (dut.vreg[r][i] !== 32'd0) begin
                    tests_failed++;
                    $display("FAIL reset_reg r%0d[%0d]: got %h expected 0", r, i, dut.vreg[r][i]);
                end
            end
        end
    endtask

    task automatic test_sum;
        int lat;
        do_cmd(OP_LOAD, 2'd0, 5'd0, lat);
        tests_run++;
        if (lat !== 17) begin
            tests_failed++;
            $display("FAIL sum_latency: got %0d expected 17", lat);
        end
        do_cmd(OP_LOAD, 2'd1, 5'd1, lat);
        do_cmd(OP_ADD, 2'd0, 5'd0, lat);
        tests_run++;
        if (lat !== 17) begin
            tests_failed++;
            $display("FAIL add_latency: got %0d expected 17", lat);
        end
        do_cmd(OP_STORE, 2'd2, 5'd31, lat);
        do_cmd(OP_STORE, 2'd3, 5'd30, lat);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (dut.memory.mem[496 + i] !== 32'(16 + 2 * i)) begin
                tests_failed++;
                $display("FAIL sum_lo[%0d]: got %h expected %h", i,
                         dut.memory.mem[496 + i], 32'(16 + 2 * i));
            end
            tests_run++;
            if (dut.memory.mem[480 + i] !== 32'd0) begin
                tests_failed++;
                $display("FAIL sum_carry[%0d]: got %h expected 0", i, dut.memory.mem[480 + i]);
            end
        end
    endtask

    task automatic test_multiply;
        int lat;
        logic [31:0] exp_lo, exp_hi;
        do_cmd(OP_LOAD, 2'd0, 5'd20, lat);
        do_cmd(OP_LOAD, 2'd1, 5'd21, lat);
        do_cmd(OP_MUL, 2'd0, 5'd0, lat);
        tests_run++;
        if (lat !== 17) begin
            tests_failed++;
            $display("FAIL mul_latency: got %0d expected 17", lat);
        end
        do_cmd(OP_STORE, 2'd2, 5'd16, lat);
        do_cmd(OP_STORE, 2'd3, 5'd15, lat);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_lo = (i < 8) ? pow2(16 + 2 * i) : 32'd0;
            exp_hi = (i < 8) ? 32'd0 : pow2(2 * i - 16);
            tests_run++;
            if (dut.memory.mem[256 + i] !== exp_lo) begin
                tests_failed++;
                $display("FAIL mul_lo[%0d]: got %h expected %h", i, dut.memory.mem[256 + i], exp_lo);
            end
            tests_run++;
            if (dut.memory.mem[240 + i] !== exp_hi) begin
                tests_failed++;
                $display("FAIL mul_hi[%0d]: got %h expected %h", i, dut.memory.mem[240 + i], exp_hi);
            end
        end
    endtask

    task automatic test_carry;
        int lat;
        for (int i = 0; i < 16; i++) begin
            dut.memory.mem[32 + i] = 32'hFFFF_FFFF;
            dut.memory.mem[48 + i] = 32'd1;
        end
        do_cmd(OP_LOAD, 2'd0, 5'd2, lat);
        do_cmd(OP_LOAD, 2'd1, 5'd3, lat);
        do_cmd(OP_ADD, 2'd0, 5'd0, lat);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (dut.vreg[2][i] !== 32'd0) begin
                tests_failed++;
                $display("FAIL carry_sum[%0d]: got %h expected 0", i, dut.vreg[2][i]);
            end
            tests_run++;
            if (dut.vreg[3][i] !== 32'd1) begin
                tests_failed++;
                $display("FAIL carry_bit[%0d]: got %h expected 1", i, dut.vreg[3][i]);
            end
        end
    endtask

    task automatic test_handshake;
        int acc_n, done_n;
        int acc_c[4];
        int done_c[4];
        acc_n  = 0;
        done_n = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            if (c == 0) begin
                opcode = OP_LOAD;  reg_addr = 2'd0; mem_addr = 5'd5;
            end else if (c == 18) begin
                opcode = OP_LOAD;  reg_addr = 2'd1; mem_addr = 5'd7;
            end else if (c < 18) begin
                opcode = (c % 2 == 1) ? OP_STORE : OP_MUL;
                reg_addr = 2'd1; mem_addr = 5'd6;
            end else begin
                opcode = (c % 2 == 1) ? OP_STORE : OP_ADD;
                reg_addr = 2'd0; mem_addr = 5'd8;
            end
            if (cmd_ready) begin
                if (acc_n < 4) acc_c[acc_n] = c;
                acc_n++;
            end
            if (done) begin
                if (done_n < 4) done_c[done_n] = c;
                done_n++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if (acc_n !== 2 || acc_c[0] !== 0 || acc_c[1] !== 18) begin
            tests_failed++;
            $display("FAIL hs_accepts: got %0d accepts (first %0d, second %0d) expected 2 at 0,18",
                     acc_n, acc_c[0], acc_c[1]);
        end
        tests_run++;
        if (done_n !== 2 || done_c[0] !== 17 || done_c[1] !== 35) begin
            tests_failed++;
            $display("FAIL hs_done: got %0d done cycles (%0d, %0d) expected 2 at 17,35",
                     done_n, done_c[0], done_c[1]);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (dut.vreg[0][i] !== pow2(16 + i) || dut.vreg[1][i] !== pow2(16 + i)) begin
                tests_failed++;
                $display("FAIL hs_loads[%0d]: got r0=%h r1=%h expected %h", i,
                         dut.vreg[0][i], dut.vreg[1][i], pow2(16 + i));
            end
            tests_run++;
            if (dut.vreg[2][i] !== 32'd0 || dut.vreg[3][i] !== 32'd0) begin
                tests_failed++;
                $display("FAIL hs_r23[%0d]: got r2=%h r3=%h expected 0", i,
                         dut.vreg[2][i], dut.vreg[3][i]);
            end
            tests_run++;
            if (dut.memory.mem[96 + i] !== pow2(i) || dut.memory.mem[128 + i] !== pow2(i)) begin
                tests_failed++;
                $display("FAIL hs_mem[%0d]: got blk6=%h blk8=%h expected %h", i,
                         dut.memory.mem[96 + i], dut.memory.mem[128 + i], pow2(i));
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] exp;
        @(negedge clk);
        opcode    = OP_STORE;
        reg_addr  = 2'd0;
        mem_addr  = 5'd12;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL abort_outputs: ready/busy/done got %b expected 100",
                     {cmd_ready, busy, done});
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 4) ? pow2(16 + i) : pow2(i);
            tests_run++;
            if (dut.memory.mem[192 + i] !== exp) begin
                tests_failed++;
                $display("FAIL abort_mem[%0d]: got %h expected %h", i, dut.memory.mem[192 + i], exp);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                tests_run++;
                if (dut.vreg[r][i] !== 32'd0) begin
                    tests_failed++;
                    $display("FAIL abort_reg r%0d[%0d]: got %h expected 0", r, i, dut.vreg[r][i]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        opcode    = 2'd0;
        reg_addr  = 2'd0;
        mem_addr  = 5'd0;
        preload();
        test_reset();
        test_sum();
        test_multiply();
        test_carry();
        test_handshake();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
